// File: rtl/rom_arbiter_pkg.sv
// Shared constants for the ROM arbiter slice: default widths, requester count
// and the fixed meaning of each requester port.
package rom_arbiter_pkg;

   localparam int ROM_DATA_WIDTH = 32;
   localparam int ROM_ADDR_WIDTH = 12;
   localparam int NREQ           = 2;

   localparam int PORT_IFETCH = 0;
   localparam int PORT_DLOAD  = 1;

   // Width of a port index; a single-port build still gets a 1-bit index.
   function automatic int port_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rom_rsp_buf.sv
// Two-entry response FIFO for one requester: head drives the response port,
// skid catches the word that arrives while the head is still being held.
module rom_rsp_buf
   import rom_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  rsp_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            occ,
   output logic                  pop
);

   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;

   assign rsp_valid = (occ != 2'd0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_data  = head;

   // A pop shifts skid into head; a simultaneous push lands behind whatever remains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         skid <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  head <= push_data;
               end else begin
                  skid <= push_data;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= skid;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= skid;
                  skid <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && (occ == 2'd2) && !pop));

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between several read ports,
// with a per-port two-entry response buffer so a stalled port never blocks others.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = ROM_DATA_WIDTH,
   parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
   parameter int NREQ       = rom_arbiter_pkg::NREQ
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [NREQ*DATA_WIDTH-1:0] rsp_data,
   input  logic [NREQ-1:0]            rsp_ready,
   output logic [ADDR_WIDTH-1:0]      rom_address,
   input  logic [DATA_WIDTH-1:0]      rom_q
);

   localparam int PW = port_bits(NREQ);

   logic [PW-1:0]         last_grant;
   logic [PW-1:0]         inflight_port;
   logic                  inflight_valid;
   logic [NREQ-1:0]       valid_q;
   logic [ADDR_WIDTH-1:0] addr_hold;

   logic [NREQ-1:0]       eligible;
   logic [NREQ-1:0]       push;
   logic [NREQ-1:0]       pop;
   logic [1:0]            occ [NREQ];

   logic                  found_c;
   logic                  found_e;
   logic [PW-1:0]         pick_c;
   logic [PW-1:0]         pick_e;
   logic [PW-1:0]         grant_idx;
   logic [PW-1:0]         idx_p;
   int                    idx;
   logic                  any_grant;
   logic                  any_xfer;

   for (genvar i = 0; i < NREQ; i++) begin : g_port
      assign push[i]     = inflight_valid && (inflight_port == PW'(i));
      assign eligible[i] = ({2'b00, push[i]} + {1'b0, occ[i]} - {2'b00, pop[i]}) < 3'd2;

      rom_rsp_buf #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_buf (
         .clk       (clk),
         .reset     (reset),
         .push      (push[i]),
         .push_data (rom_q),
         .rsp_ready (rsp_ready[i]),
         .rsp_valid (rsp_valid[i]),
         .rsp_data  (rsp_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .occ       (occ[i]),
         .pop       (pop[i])
      );
   end

   // Contenders are ports that requested last cycle, so a port's ready never
   // depends on its own valid; with no contender the first eligible port is offered.
   always_comb begin
      found_c = 1'b0;
      found_e = 1'b0;
      pick_c  = '0;
      pick_e  = '0;
      idx     = 0;
      idx_p   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_p = PW'(idx);
         if (!found_c && eligible[idx_p] && valid_q[idx_p]) begin
            found_c = 1'b1;
            pick_c  = idx_p;
         end
         if (!found_e && eligible[idx_p]) begin
            found_e = 1'b1;
            pick_e  = idx_p;
         end
      end
      grant_idx = found_c ? pick_c : pick_e;
      any_grant = reset && (found_c || found_e);
   end

   always_comb begin
      req_ready = '0;
      if (any_grant) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign any_xfer = |(req_valid & req_ready);

   always_comb begin
      rom_address = addr_hold;
      if (any_xfer) begin
         rom_address = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant     <= PW'(NREQ - 1);
         inflight_valid <= 1'b0;
         inflight_port  <= '0;
         valid_q        <= '0;
         addr_hold      <= '0;
      end else begin
         valid_q        <= req_valid;
         addr_hold      <= rom_address;
         inflight_valid <= any_xfer;
         if (any_xfer) begin
            inflight_port <= grant_idx;
            last_grant    <= grant_idx;
         end
      end
   end

   grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, hand-written corner sequences
// and a randomized run checked against per-port queues of expected ROM words.
module tb_rom_arbiter;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    rsp_valid;
   logic [NR*DW-1:0] rsp_data;
   logic [NR-1:0]    rsp_ready = '0;
   logic [AW-1:0]    rom_address;
   logic [DW-1:0]    rom_q = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] exp_q [NR][$];
   bit            pop_m;
   bit            room_m;

   typedef struct {
      bit          rst_before;
      bit          chk_ready;
      logic [1:0]  valid;
      logic [11:0] a0;
      logic [11:0] a1;
      logic [1:0]  rrdy;
      logic [1:0]  exp_ready;
      logic [1:0]  exp_rvalid;
      logic [11:0] exp_a0;
      logic [11:0] exp_a1;
      logic [11:0] exp_rom;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   rom_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NREQ       (NR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_ready   (rsp_ready),
      .rom_address (rom_address),
      .rom_q       (rom_q)
   );

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return {a, 20'h0} ^ (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Synchronous ROM: word for the address sampled at the edge appears next cycle.
   always @(posedge clk) rom_q <= rom_word(rom_address);

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
      end
   endtask

   // Scoreboard: each transfer queues the ROM word owed to that port; each pop
   // must match the oldest owed word, and a port may only be offered a grant
   // while it owes fewer than two words after this cycle's pop.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NR; i++) exp_q[i].delete();
      end else begin
         for (int i = 0; i < NR; i++) begin
            pop_m  = rsp_valid[i] && rsp_ready[i];
            room_m = (exp_q[i].size() - int'(pop_m)) < 2;
            if (req_ready[i]) check_val($sformatf("grant_room_p%0d", i), room_m, 1);
            if (pop_m) begin
               check_val($sformatf("rsp_owed_p%0d", i), exp_q[i].size() != 0, 1);
               if (exp_q[i].size() != 0)
                  check_val($sformatf("sb_rsp_data_p%0d", i), rsp_data[i*DW +: DW], exp_q[i].pop_front());
            end
            if (req_valid[i] && req_ready[i])
               exp_q[i].push_back(rom_word(req_addr[i*AW +: AW]));
         end
         check_val("ready_onehot0", $onehot0(req_ready), 1);
      end
   end

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      rsp_ready = '0;
      @(negedge clk);
      check_val("reset_req_ready", req_ready, 0);
      check_val("reset_rsp_valid", rsp_valid, 0);
      check_val("reset_rsp_data", rsp_data, 0);
      check_val("reset_rom_address", rom_address, 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic apply_stimulus(input vec_t v);
      if (v.rst_before) do_reset();
      req_valid = v.valid;
      req_addr  = {v.a1, v.a0};
      rsp_ready = v.rrdy;
   endtask

   task automatic check_output(input vec_t v, input int row);
      @(negedge clk);
      if (v.chk_ready) check_val($sformatf("row%0d_req_ready", row), req_ready, v.exp_ready);
      check_val($sformatf("row%0d_rsp_valid", row), rsp_valid, v.exp_rvalid);
      check_val($sformatf("row%0d_rom_address", row), rom_address, v.exp_rom);
      if (v.exp_rvalid[0]) check_val($sformatf("row%0d_rsp_data0", row), rsp_data[DW-1:0], rom_word(v.exp_a0));
      if (v.exp_rvalid[1]) check_val($sformatf("row%0d_rsp_data1", row), rsp_data[2*DW-1:DW], rom_word(v.exp_a1));
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int p0;
      int p1;
      logic [DW-1:0] got1 [$];

      // Port 0 streams 0x000..0x003, then both ports request continuously.
      //           rst  chk  valid  a0      a1      rrdy   ready  rvalid ea0     ea1     rom
      vecs[0]  = '{1'b1, 1'b1, 2'b01, 12'h000, 12'h000, 2'b11, 2'b01, 2'b00, 12'h000, 12'h000, 12'h000};
      vecs[1]  = '{1'b0, 1'b1, 2'b01, 12'h001, 12'h000, 2'b11, 2'b01, 2'b00, 12'h000, 12'h000, 12'h001};
      vecs[2]  = '{1'b0, 1'b1, 2'b01, 12'h002, 12'h000, 2'b11, 2'b01, 2'b01, 12'h000, 12'h000, 12'h002};
      vecs[3]  = '{1'b0, 1'b1, 2'b01, 12'h003, 12'h000, 2'b11, 2'b01, 2'b01, 12'h001, 12'h000, 12'h003};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 12'h000, 12'h000, 2'b11, 2'b00, 2'b01, 12'h002, 12'h000, 12'h003};
      vecs[5]  = '{1'b0, 1'b0, 2'b00, 12'h000, 12'h000, 2'b11, 2'b00, 2'b01, 12'h003, 12'h000, 12'h003};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 12'h000, 12'h000, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 12'h003};
      vecs[7]  = '{1'b1, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b01, 2'b00, 12'h000, 12'h000, 12'h010};
      vecs[8]  = '{1'b0, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b10, 2'b00, 12'h000, 12'h000, 12'h800};
      vecs[9]  = '{1'b0, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b01, 2'b01, 12'h010, 12'h000, 12'h010};
      vecs[10] = '{1'b0, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b10, 2'b10, 12'h000, 12'h800, 12'h800};
      vecs[11] = '{1'b0, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b01, 2'b01, 12'h010, 12'h000, 12'h010};
      vecs[12] = '{1'b0, 1'b1, 2'b11, 12'h010, 12'h800, 2'b11, 2'b10, 2'b10, 12'h000, 12'h800, 12'h800};

      for (int r = 0; r < 13; r++) begin
         apply_stimulus(vecs[r]);
         check_output(vecs[r], r);
      end

      // Port 1 backpressured while port 0 keeps requesting.
      do_reset();
      p0 = 0;
      p1 = 0;
      rsp_ready = 2'b01;
      for (int k = 0; k < 8; k++) begin
         req_valid = {(p1 < 3), 1'b1};
         req_addr  = {12'h100 + 12'(p1), 12'h040 + 12'(k)};
         @(negedge clk);
         if (req_valid[1] && req_ready[1]) p1++;
         if (req_valid[0] && req_ready[0]) p0++;
         @(posedge clk); #1;
      end
      check_val("bp_port1_transfers", p1, 2);
      check_val("bp_port0_transfers", p0, 6);
      req_valid = 2'b10;
      req_addr  = {12'h102, 12'h000};
      @(negedge clk);
      check_val("bp_port1_not_ready", req_ready[1], 0);
      check_val("bp_port1_rsp_valid", rsp_valid[1], 1);
      check_val("bp_port1_head", rsp_data[2*DW-1:DW], rom_word(12'h100));
      @(posedge clk); #1;
      rsp_ready = 2'b11;
      for (int k = 0; k < 10; k++) begin
         req_valid = {(p1 < 3), 1'b0};
         req_addr  = {12'h100 + 12'(p1), 12'h000};
         @(negedge clk);
         if (rsp_valid[1] && rsp_ready[1]) got1.push_back(rsp_data[2*DW-1:DW]);
         if (req_valid[1] && req_ready[1]) p1++;
         @(posedge clk); #1;
      end
      check_val("bp_port1_rsp_count", got1.size(), 3);
      for (int j = 0; j < 3 && j < got1.size(); j++)
         check_val($sformatf("bp_port1_rsp%0d", j), got1[j], rom_word(12'h100 + 12'(j)));

      // Reset pulsed right after a port 0 transfer discards its response.
      do_reset();
      rsp_ready = 2'b11;
      req_valid = 2'b01;
      req_addr  = {12'h000, 12'h020};
      @(negedge clk);
      check_val("mid_reset_pre_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("mid_reset_req_ready", req_ready, 0);
      check_val("mid_reset_rsp_valid", rsp_valid, 0);
      check_val("mid_reset_rsp_data", rsp_data, 0);
      check_val("mid_reset_rom_address", rom_address, 0);
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_val($sformatf("post_reset_no_rsp%0d", k), rsp_valid, 0);
         @(posedge clk); #1;
      end

      // Random traffic on both ports against the scoreboard.
      for (int c = 0; c < 10000; c++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_addr  = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
         rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
         @(posedge clk); #1;
      end
      req_valid = '0;
      rsp_ready = 2'b11;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_val("drain_port0_owed", exp_q[0].size(), 0);
      check_val("drain_port1_owed", exp_q[1].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
